// File: rtl/fpu_fmt_pkg.sv
// Shared format definitions for the custom 32-bit float: sign, 6-bit biased exponent, 25-bit fraction.
// Imported by the integer encoder and the floating-point adder.
package fpu_fmt_pkg;

    localparam int BIAS   = 31;
    localparam int EXP_W  = 6;
    localparam int MANT_W = 25;

    localparam int ST_ZERO    = 0;
    localparam int ST_INEXACT = 1;
    localparam int ST_NEG     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } state_t;

    function automatic logic [31:0] pack_float(
        input logic              sign,
        input logic [EXP_W-1:0]  exp_biased,
        input logic [MANT_W-1:0] frac
    );
        return {sign, exp_biased, frac};
    endfunction

endpackage

// File: rtl/int_to_fp.sv
// Iterative signed-integer to custom-float encoder: one normalizing shift per clock,
// truncating rounding with an inexact flag for any fraction bits that fall off.
module int_to_fp
    import fpu_fmt_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);

    state_t             state_r;
    state_t             state_s;
    logic               busy_r;
    logic               done_r;
    logic [31:0]        data_r;
    logic [3:0]         status_r;
    logic               sign_r;
    logic [31:0]        mag_r;
    logic [EXP_W-1:0]   exp_r;
    logic               zero_s;
    logic               shift_s;

    assign zero_s  = (mag_r == 32'd0);
    assign shift_s = !zero_s && !mag_r[31];

    // Next-state decode; a zero magnitude leaves NORM at once so it never shifts forever.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = NORM;
                end else begin
                    state_s = IDLE;
                end
            end
            NORM: begin
                if (shift_s) begin
                    state_s = NORM;
                end else begin
                    state_s = PACK;
                end
            end
            PACK:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; busy is registered from the next state so it tracks state != IDLE exactly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Datapath: operand capture, normalization shifts, and result packing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sign_r   <= 1'b0;
            mag_r    <= 32'd0;
            exp_r    <= '0;
            done_r   <= 1'b0;
            data_r   <= 32'd0;
            status_r <= 4'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sign_r <= int_in[31];
                        // -2^31 negates to itself, which is the correct unsigned magnitude.
                        mag_r  <= int_in[31] ? (32'd0 - int_in) : int_in;
                        exp_r  <= EXP_W'(31);
                    end else begin
                        mag_r <= mag_r;
                    end
                end
                NORM: begin
                    if (shift_s) begin
                        mag_r <= {mag_r[30:0], 1'b0};
                        exp_r <= exp_r - {{(EXP_W-1){1'b0}}, 1'b1};
                    end else begin
                        mag_r <= mag_r;
                    end
                end
                PACK: begin
                    done_r <= 1'b1;
                    if (zero_s) begin
                        data_r   <= 32'h0000_0000;
                        status_r <= 4'b0001;
                    end else begin
                        data_r                <= pack_float(sign_r, exp_r + BIAS_E, mag_r[30 -: MANT_W]);
                        status_r              <= 4'b0000;
                        status_r[ST_INEXACT]  <= |mag_r[5:0];
                        status_r[ST_NEG]      <= sign_r;
                        status_r[ST_ZERO]     <= 1'b0;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign data_out   = data_r;
    assign status_out = status_r;

endmodule

// File: tb/tb_int_to_fp.sv
// Scoreboard bench for int_to_fp: a driver pushes expected results, a monitor pops and compares on done.
module tb_int_to_fp;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  status;
        int          done_cyc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] int_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    logic prev_done  = 1'b0;

    int_to_fp dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .int_in     (int_in),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .status_out (status_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference: value = sign * 1.frac * 2^p with p = floor(log2 |v|), fraction truncated.
    function automatic exp_t model(input logic [31:0] v);
        exp_t   e;
        logic   sgn;
        longint m;
        longint scaled;
        longint frac;
        int     p;
        logic   lost;
        sgn = v[31];
        m   = sgn ? (64'd4294967296 - longint'(v)) : longint'(v);
        if (m == 64'd0) begin
            e.data     = 32'h0;
            e.status   = 4'h1;
            e.done_cyc = 2;
        end else begin
            p      = $clog2(m + 64'd1) - 1;
            scaled = m * 64'd33554432;
            frac   = (scaled >> p) - 64'd33554432;
            lost   = (scaled % (64'd1 << p)) != 64'd0;
            e.data     = {sgn, 6'(p + 31), 25'(frac)};
            e.status   = {1'b0, sgn, lost, 1'b0};
            e.done_cyc = 2 + (31 - p);
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest expectation, in value and in arrival cycle.
    always @(negedge clock) begin
        if (reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data_out", data_out, e.data);
                    chk("status_out", {28'd0, status_out}, {28'd0, e.status});
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                end
                if (prev_done) chk("done_width", 32'd2, 32'd1);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Issue one conversion from a negedge-aligned point; optionally poke start while busy.
    task automatic convert(input logic [31:0] v, input logic [31:0] d, input logic [3:0] s,
                           input int lat, input bit poke);
        exp_t e;
        e.data     = d;
        e.status   = s;
        e.done_cyc = cyc + 1 + lat;
        sb.push_back(e);
        start  = 1'b1;
        int_in = v;
        @(negedge clock);
        start  = poke;
        int_in = poke ? 32'd5 : $urandom;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        @(negedge clock);
        start  = 1'b0;
        int_in = $urandom;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
            #1;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        logic [31:0] v;
        reset  = 1'b0;
        start  = 1'b0;
        int_in = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_status", {28'd0, status_out}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        convert(32'h0000_0001, 32'h3E00_0000, 4'h0, 33, 1'b0);
        convert(32'hFFFF_FFFF, 32'hBE00_0000, 4'h4, 33, 1'b0);
        convert(32'h0000_0003, 32'h4100_0000, 4'h0, 32, 1'b1);
        convert(32'h7FFF_FFFF, 32'h7BFF_FFFF, 4'h2, 3, 1'b0);
        convert(32'h8000_0000, 32'hFC00_0000, 4'h4, 2, 1'b0);
        convert(32'h0000_0000, 32'h0000_0000, 4'h1, 2, 1'b1);
        repeat (3) @(negedge clock);
        chk("zero_hold_data", data_out, 32'd0);
        chk("zero_hold_busy", {31'd0, busy}, 32'd0);

        convert(32'hFFFF_FFFD, 32'hC100_0000, 4'h4, 32, 1'b0);
        // Abort a conversion of 1 partway through with an asynchronous reset.
        start  = 1'b1;
        int_in = 32'd1;
        @(posedge clock);
        repeat (10) @(posedge clock);
        #1;
        start = 1'b0;
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_data", data_out, 32'd0);
        chk("abort_status", {28'd0, status_out}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        chk("abort_no_done_data", data_out, 32'd0);
        convert(32'h0000_0002, 32'h4000_0000, 4'h0, 32, 1'b0);

        for (int n = 0; n < 150; n++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
            if (n % 37 == 0) v = 32'd0;
            e = model(v);
            convert(v, e.data, e.status, e.done_cyc, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
